// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - BRAM-backed data responder with read-modify-write for partial stores
module dram_responder #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [3:0]            req_we,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  bram_en,
  output logic                  bram_wen,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_din,
  input  logic [31:0]           bram_dout
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [31:0]           resp_rdata_q;
  logic                  bram_en_q;
  logic                  bram_wen_q;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic [31:0]           bram_din_q;
  logic [3:0]            we_q;
  logic [31:0]           wdata_q;

  logic [31:0]           off_d;
  logic                  range_err_d;
  logic                  lane_err_d;
  logic                  req_err_d;
  logic [31:0]           merged_d;

  // Validate the incoming request: word offset must fall inside the BRAM and
  // the lane mask must be a naturally aligned byte, halfword or word.
  always_comb begin
    off_d       = req_addr - BASE_ADDR;
    // off[31:2] >= depth is the same as off >= 4*depth; addresses below the
    // base wrap to huge offsets and are caught here too.
    range_err_d = (off_d >= (32'd4 << ADDR_WIDTH));
    case (req_we)
      4'b0000:          lane_err_d = 1'b0;
      4'b1111, 4'b0011: lane_err_d = (req_addr[1:0] != 2'b00);
      4'b1100:          lane_err_d = (req_addr[1:0] != 2'b10);
      default:          lane_err_d = (req_we != (4'b0001 << req_addr[1:0]));
    endcase
    req_err_d = range_err_d | lane_err_d;
  end

  // Merge latched write lanes over the word just read back from the BRAM.
  always_comb begin
    merged_d = '0;
    for (int i = 0; i < 4; i++) begin
      merged_d[8*i +: 8] = we_q[i] ? wdata_q[8*i +: 8] : bram_dout[8*i +: 8];
    end
  end

  // Request FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      bram_en_q    <= 1'b0;
      bram_wen_q   <= 1'b0;
      bram_addr_q  <= '0;
      bram_din_q   <= '0;
      we_q         <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            wdata_q     <= req_wdata;
            if (req_err_d) begin
              // Rejected requests never touch the BRAM.
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= RESP;
            end else begin
              bram_en_q   <= 1'b1;
              bram_addr_q <= off_d[ADDR_WIDTH+1:2];
              if (req_we == 4'b1111) begin
                bram_wen_q <= 1'b1;
                bram_din_q <= req_wdata;
                state_q    <= WR;
              end else begin
                // Reads and partial writes both start with a BRAM read.
                state_q <= RD;
              end
            end
          end
        end
        RD: begin
          bram_en_q <= 1'b0;
          state_q   <= RDW;
        end
        RDW: begin
          if (we_q == 4'b0000) begin
            resp_rdata_q <= bram_dout;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            bram_din_q <= merged_d;
            bram_en_q  <= 1'b1;
            bram_wen_q <= 1'b1;
            state_q    <= WR;
          end
        end
        WR: begin
          bram_en_q    <= 1'b0;
          bram_wen_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign bram_en    = bram_en_q;
  assign bram_wen   = bram_wen_q;
  assign bram_addr  = bram_addr_q;
  assign bram_din   = bram_din_q;

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - randomized self-checking bench for dram_responder
module tb_dram_responder;

  localparam int          AW    = 8;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic [3:0]    req_we;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          bram_en;
  logic          bram_wen;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_din;
  logic [31:0]   bram_dout;

  logic [31:0]   mem     [DEPTH];
  logic [31:0]   ref_mem [DEPTH];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [31:0]   pre_data;
  logic [31:0]   last_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] pats [10] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001,
                            4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b0101};

  dram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bram_en    (bram_en),
    .bram_wen   (bram_wen),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_dout  (bram_dout)
  );

  always #5 clk = ~clk;

  // Word-wide synchronous single-port BRAM, plus a bench-side preload port.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bram_en) begin
      if (bram_wen) mem[bram_addr] <= bram_din;
      else          bram_dout      <= mem[bram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [31:0] addr, input logic [3:0] we);
    logic [31:0] off;
    int n, a;
    off = addr - BASE;
    if ((off >> 2) >= 32'(DEPTH)) return 1'b1;
    if (we == 4'b0000) return 1'b0;
    n = $countones(we);
    a = int'(addr[1:0]);
    if (!(n == 1 || n == 2 || n == 4)) return 1'b1;
    if ((a % n) != 0) return 1'b1;
    return int'(we) != (((1 << n) - 1) << a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic preset(input int idx, input logic [31:0] val);
    pre_we   = 1'b1;
    pre_addr = AW'(idx);
    pre_data = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Called at a negedge during an IDLE cycle; returns at the negedge of the
  // IDLE cycle following the response.
  task automatic do_req(input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] wd, input bit hold);
    bit          err;
    int          exp_lat, exp_en, lat, en_cnt, wen_cnt, busy_bad, idx;
    logic [31:0] off;
    err     = ref_err(addr, we);
    exp_lat = err ? 1 : (we == 4'b0000) ? 3 : (we == 4'b1111) ? 2 : 4;
    exp_en  = err ? 0 : (we == 4'b0000 || we == 4'b1111) ? 1 : 2;
    off     = addr - BASE;
    idx     = int'((off >> 2) % DEPTH);
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    req_wdata = wd;
    check("ready_idle", req_ready, 1);
    @(posedge clk);
    lat = 0; en_cnt = 0; wen_cnt = 0; busy_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready) busy_bad++;
      if (bram_en)   en_cnt++;
      if (bram_wen)  wen_cnt++;
    end while (!resp_valid && lat < 8);
    if (!hold) req_valid = 1'b0;
    if (!err && we != 4'b0000) ref_mem[idx] = merge(ref_mem[idx], we, wd);
    if (!err && we == 4'b0000) last_rdata = ref_mem[idx];
    check("latency", lat, exp_lat);
    check("resp_err", resp_err, err);
    check("busy_ready", busy_bad, 0);
    check("bram_en_cycles", en_cnt, exp_en);
    check("wen_pulses", wen_cnt, (!err && we != 4'b0000) ? 1 : 0);
    check("resp_rdata", resp_rdata, last_rdata);
    @(negedge clk);
    check("resp_single", resp_valid, 0);
    check("err_cleared", resp_err, 0);
  endtask

  initial begin
    int          stray;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = '0; req_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; last_rdata = '0;

    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) preset(i, 32'h0);

    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_wen", bram_wen, 0);
    check("rst_bram_addr", 32'(bram_addr), 0);
    check("rst_bram_din", bram_din, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(BASE + 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0);
    do_req(BASE + 32'h10, 4'b0000, 32'h0, 1'b0);
    check("read_deadbeef", resp_rdata, 32'hDEADBEEF);

    preset(8, 32'h11223344);
    do_req(BASE + 32'h22, 4'b0100, 32'h00AA0000, 1'b0);
    do_req(BASE + 32'h20, 4'b0000, 32'h0, 1'b0);
    check("byte_rmw", resp_rdata, 32'h11AA3344);

    preset(8, 32'h11223344);
    do_req(BASE + 32'h22, 4'b1100, 32'h55660000, 1'b0);
    do_req(BASE + 32'h20, 4'b0000, 32'h0, 1'b0);
    check("half_rmw", resp_rdata, 32'h55663344);

    preset(8, 32'h11223344);
    do_req(BASE + 32'h21, 4'b0110, 32'hFFFFFFFF, 1'b0);
    do_req(BASE + 32'h22, 4'b0001, 32'hFFFFFFFF, 1'b0);
    do_req(BASE + 32'(4 * DEPTH), 4'b1111, 32'hFFFFFFFF, 1'b0);
    do_req(BASE - 32'h4, 4'b1111, 32'hFFFFFFFF, 1'b0);
    check("err_mem_intact", mem[8], 32'h11223344);

    // Reset during the RDW cycle of a partial write.
    req_valid = 1'b1; req_addr = BASE + 32'h20; req_we = 4'b0001; req_wdata = 32'h000000FF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rdw_rst_ready", req_ready, 1);
    check("rdw_rst_valid", resp_valid, 0);
    check("rdw_rst_wen", bram_wen, 0);
    rst_n = 1'b1; req_valid = 1'b0; last_rdata = '0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    check("rdw_rst_no_resp", stray, 0);
    check("rdw_rst_mem", mem[8], 32'h11223344);

    // Back-to-back mixed traffic with req_valid held high throughout.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
        1:       a = BASE - 32'h1 - 32'($urandom_range(0, 15));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      do_req(a, pats[$urandom_range(0, 9)], $urandom, i != 39);
    end

    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
